// File: rtl/ysyx_210247_axi_ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_210247_axi_ram_pkg: AXI response codes, FSM states, range helper.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ysyx_210247_axi_ram_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Widened to 65 bits so a window ending at 2^64 cannot wrap.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int unsigned words_log2);
    logic [64:0] limit;
    limit = {1'b0, base} + (65'd8 << words_log2);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_210247_axi_ram_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_210247_axi_ram_array: 64-bit word RAM, byte-masked sync write port,   |
// | combinational read port (read-before-write on the same edge).              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ysyx_210247_axi_ram_array #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic [ADDR_W-1:0] raddr,
  output logic [63:0]       rdata
);

  logic [63:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/ysyx_210247_axi_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_210247_axi_ram: AXI4 INCR-burst responder backed by an in-RTL RAM,    |
// | independent read/write channels, one outstanding burst per direction.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ysyx_210247_axi_ram
  import ysyx_210247_axi_ram_pkg::*;
#(
  parameter logic [63:0] MEM_BASE       = 64'h8000_0000,
  parameter int          MEM_WORDS_LOG2 = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        axi_aw_ready_o,
  input  logic        axi_aw_valid_i,
  input  logic [63:0] axi_aw_addr_i,
  input  logic [3:0]  axi_aw_id_i,
  input  logic [7:0]  axi_aw_len_i,
  output logic        axi_w_ready_o,
  input  logic        axi_w_valid_i,
  input  logic [63:0] axi_w_data_i,
  input  logic [7:0]  axi_w_strb_i,
  input  logic        axi_w_last_i,
  input  logic        axi_b_ready_i,
  output logic        axi_b_valid_o,
  output logic [1:0]  axi_b_resp_o,
  output logic [3:0]  axi_b_id_o,
  output logic        axi_ar_ready_o,
  input  logic        axi_ar_valid_i,
  input  logic [63:0] axi_ar_addr_i,
  input  logic [3:0]  axi_ar_id_i,
  input  logic [7:0]  axi_ar_len_i,
  input  logic        axi_r_ready_i,
  output logic        axi_r_valid_o,
  output logic [63:0] axi_r_data_o,
  output logic [1:0]  axi_r_resp_o,
  output logic        axi_r_last_o,
  output logic [3:0]  axi_r_id_o
);

  localparam int AW = MEM_WORDS_LOG2;

  w_state_t    wr_state;
  logic [63:0] wr_addr;
  logic [7:0]  wr_len;
  logic [7:0]  wr_cnt;
  logic        wr_decerr;

  r_state_t    rd_state;
  logic [63:0] rd_addr;
  logic [7:0]  rd_len;
  logic [7:0]  rd_cnt;

  logic          wr_fire;
  logic          wr_in_range;
  logic          wr_at_len;
  logic          wr_done;
  logic          wr_slv_now;
  logic [1:0]    wr_final_resp;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  logic          ar_fire;
  logic          r_fire;
  logic [63:0]   rd_next_addr;
  logic [63:0]   rd_lookup_addr;
  logic          rd_lookup_ok;
  logic [AW-1:0] mem_raddr;
  logic [63:0]   mem_rdata;
  logic [63:0]   rd_beat_data;
  logic [1:0]    rd_beat_resp;

  // Write datapath
  assign wr_fire       = (wr_state == W_DATA) && axi_w_valid_i && axi_w_ready_o;
  assign wr_in_range   = addr_in_range(wr_addr, MEM_BASE, MEM_WORDS_LOG2);
  assign wr_at_len     = (wr_cnt == wr_len);
  assign wr_done       = wr_at_len || axi_w_last_i;
  assign wr_slv_now    = axi_w_last_i != wr_at_len;
  assign mem_we        = wr_fire && wr_in_range;
  assign mem_waddr     = AW'((wr_addr - MEM_BASE) >> 3);
  assign wr_final_resp = (wr_decerr || !wr_in_range) ? AXI_RESP_DECERR :
                         wr_slv_now                  ? AXI_RESP_SLVERR :
                                                       AXI_RESP_OKAY;

  // Read lookup: idle looks at the incoming AR, a burst looks one beat ahead
  assign ar_fire        = (rd_state == R_IDLE) && axi_ar_valid_i && axi_ar_ready_o;
  assign r_fire         = (rd_state == R_DATA) && axi_r_valid_o && axi_r_ready_i;
  assign rd_next_addr   = rd_addr + 64'd8;
  assign rd_lookup_addr = (rd_state == R_IDLE) ? axi_ar_addr_i : rd_next_addr;
  assign rd_lookup_ok   = addr_in_range(rd_lookup_addr, MEM_BASE, MEM_WORDS_LOG2);
  assign mem_raddr      = AW'((rd_lookup_addr - MEM_BASE) >> 3);
  assign rd_beat_data   = rd_lookup_ok ? mem_rdata : 64'd0;
  assign rd_beat_resp   = rd_lookup_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;

  ysyx_210247_axi_ram_array #(
    .ADDR_W (AW)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (axi_w_data_i),
    .wstrb (axi_w_strb_i),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state       <= W_IDLE;
      wr_addr        <= 64'd0;
      wr_len         <= 8'd0;
      wr_cnt         <= 8'd0;
      wr_decerr      <= 1'b0;
      axi_aw_ready_o <= 1'b0;
      axi_w_ready_o  <= 1'b0;
      axi_b_valid_o  <= 1'b0;
      axi_b_resp_o   <= AXI_RESP_OKAY;
      axi_b_id_o     <= 4'd0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          axi_aw_ready_o <= 1'b1;
          if (axi_aw_valid_i && axi_aw_ready_o) begin
            wr_addr        <= axi_aw_addr_i;
            wr_len         <= axi_aw_len_i;
            wr_cnt         <= 8'd0;
            wr_decerr      <= 1'b0;
            axi_b_id_o     <= axi_aw_id_i;
            axi_aw_ready_o <= 1'b0;
            axi_w_ready_o  <= 1'b1;
            wr_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_fire) begin
            wr_addr <= wr_addr + 64'd8;
            wr_cnt  <= wr_cnt + 8'd1;
            if (!wr_in_range) wr_decerr <= 1'b1;
            if (wr_done) begin
              axi_w_ready_o <= 1'b0;
              axi_b_valid_o <= 1'b1;
              axi_b_resp_o  <= wr_final_resp;
              wr_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_b_ready_i) begin
            axi_b_valid_o  <= 1'b0;
            axi_aw_ready_o <= 1'b1;
            wr_state       <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state       <= R_IDLE;
      rd_addr        <= 64'd0;
      rd_len         <= 8'd0;
      rd_cnt         <= 8'd0;
      axi_ar_ready_o <= 1'b0;
      axi_r_valid_o  <= 1'b0;
      axi_r_data_o   <= 64'd0;
      axi_r_resp_o   <= AXI_RESP_OKAY;
      axi_r_last_o   <= 1'b0;
      axi_r_id_o     <= 4'd0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          axi_ar_ready_o <= 1'b1;
          if (ar_fire) begin
            rd_addr        <= axi_ar_addr_i;
            rd_len         <= axi_ar_len_i;
            rd_cnt         <= 8'd0;
            axi_r_id_o     <= axi_ar_id_i;
            axi_r_data_o   <= rd_beat_data;
            axi_r_resp_o   <= rd_beat_resp;
            axi_r_last_o   <= (axi_ar_len_i == 8'd0);
            axi_r_valid_o  <= 1'b1;
            axi_ar_ready_o <= 1'b0;
            rd_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (axi_r_last_o) begin
              axi_r_valid_o  <= 1'b0;
              axi_ar_ready_o <= 1'b1;
              rd_state       <= R_IDLE;
            end else begin
              rd_addr      <= rd_next_addr;
              rd_cnt       <= rd_cnt + 8'd1;
              axi_r_data_o <= rd_beat_data;
              axi_r_resp_o <= rd_beat_resp;
              axi_r_last_o <= ((rd_cnt + 8'd1) == rd_len);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_210247_axi_ram.sv
`default_nettype none
// Bench for ysyx_210247_axi_ram: vector table, directed burst corners and
// random bursts against a word-array memory model.
module tb_ysyx_210247_axi_ram;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LOG2  = 10;
  localparam logic [63:0] LIMIT = BASE + 64'd8 * (64'd1 << LOG2);

  logic        clock = 1'b0;
  logic        reset;
  logic        aw_ready, aw_valid;
  logic [63:0] aw_addr;
  logic [3:0]  aw_id;
  logic [7:0]  aw_len;
  logic        w_ready, w_valid, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_ready, b_valid;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic        ar_ready, ar_valid;
  logic [63:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic        r_ready, r_valid, r_last;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [3:0]  r_id;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mem_m  [0:(1<<LOG2)-1];
  logic [63:0] wbuf_d [0:255];
  logic [7:0]  wbuf_s [0:255];
  logic [63:0] rd_data0;
  logic [1:0]  rd_resp0;

  always #5 clock = ~clock;

  ysyx_210247_axi_ram #(
    .MEM_BASE       (BASE),
    .MEM_WORDS_LOG2 (LOG2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .axi_aw_ready_o (aw_ready),
    .axi_aw_valid_i (aw_valid),
    .axi_aw_addr_i  (aw_addr),
    .axi_aw_id_i    (aw_id),
    .axi_aw_len_i   (aw_len),
    .axi_w_ready_o  (w_ready),
    .axi_w_valid_i  (w_valid),
    .axi_w_data_i   (w_data),
    .axi_w_strb_i   (w_strb),
    .axi_w_last_i   (w_last),
    .axi_b_ready_i  (b_ready),
    .axi_b_valid_o  (b_valid),
    .axi_b_resp_o   (b_resp),
    .axi_b_id_o     (b_id),
    .axi_ar_ready_o (ar_ready),
    .axi_ar_valid_i (ar_valid),
    .axi_ar_addr_i  (ar_addr),
    .axi_ar_id_i    (ar_id),
    .axi_ar_len_i   (ar_len),
    .axi_r_ready_i  (r_ready),
    .axi_r_valid_o  (r_valid),
    .axi_r_data_o   (r_data),
    .axi_r_resp_o   (r_resp),
    .axi_r_last_o   (r_last),
    .axi_r_id_o     (r_id)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic die(input string name);
    n_err++;
    $display("FAIL %s: timed out waiting on DUT", name);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "aborted");
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  function automatic int widx(input logic [63:0] a);
    logic [63:0] off;
    off = (a - BASE) >> 3;
    return int'(off[LOG2-1:0]);
  endfunction

  // Word the model says a read beat at address a must return
  task automatic exp_word(input logic [63:0] a, output logic [63:0] d, output logic [1:0] r);
    if (in_rng(a)) begin d = mem_m[widx(a)]; r = 2'b00; end
    else begin d = 64'd0; r = 2'b11; end
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input int last_beat, output logic [1:0] resp, output int nbeats);
    int          t;
    bit          dec;
    logic [63:0] a;
    logic [1:0]  exp_r;
    @(negedge clock);
    aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len;
    t = 0;
    while (!aw_ready) begin @(negedge clock); t++; if (t > 200) die("aw_wait"); end
    @(negedge clock);
    aw_valid = 1'b0;
    dec = 1'b0; nbeats = 0;
    for (int b = 0; b < 256; b++) begin
      w_valid = 1'b1; w_data = wbuf_d[b]; w_strb = wbuf_s[b]; w_last = (b == last_beat);
      t = 0;
      while (!w_ready) begin @(negedge clock); t++; if (t > 200) die("w_wait"); end
      @(negedge clock);
      nbeats++;
      a = addr + 64'd8 * 64'(b);
      if (in_rng(a)) begin
        for (int k = 0; k < 8; k++)
          if (wbuf_s[b][k]) mem_m[widx(a)][8*k +: 8] = wbuf_d[b][8*k +: 8];
      end else dec = 1'b1;
      if (b == last_beat || b == int'(len)) break;
    end
    w_valid = 1'b0; w_last = 1'b0;
    chk("w_ready_after_last", 64'(w_ready), 64'd0);
    t = 0;
    while (!b_valid) begin @(negedge clock); t++; if (t > 200) die("b_wait"); end
    exp_r = dec ? 2'b11 : (last_beat != int'(len)) ? 2'b10 : 2'b00;
    resp = b_resp;
    chk("b_resp", 64'(b_resp), 64'(exp_r));
    chk("b_id", 64'(b_id), 64'(id));
    chk("aw_ready_in_resp", 64'(aw_ready), 64'd0);
    @(negedge clock);
    chk("b_valid_held", 64'(b_valid), 64'd1);
    chk("b_resp_held", 64'(b_resp), 64'(exp_r));
    b_ready = 1'b1;
    @(negedge clock);
    b_ready = 1'b0;
    chk("b_valid_drop", 64'(b_valid), 64'd0);
    chk("aw_ready_after_b", 64'(aw_ready), 64'd1);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [31:0] rdy_pat, input bit pat_en);
    int          t, b, c;
    bit          rdy;
    logic [63:0] ed;
    logic [1:0]  er;
    @(negedge clock);
    ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = len;
    t = 0;
    while (!ar_ready) begin @(negedge clock); t++; if (t > 200) die("ar_wait"); end
    @(negedge clock);
    ar_valid = 1'b0;
    chk("r_latency", 64'(r_valid), 64'd1);
    b = 0; c = 0;
    while (b <= int'(len)) begin
      if (c > 2000) die("r_beats");
      exp_word(addr + 64'd8 * 64'(b), ed, er);
      if (b == 0) begin rd_data0 = r_data; rd_resp0 = r_resp; end
      chk("r_valid", 64'(r_valid), 64'd1);
      chk("r_data", r_data, ed);
      chk("r_resp", 64'(r_resp), 64'(er));
      chk("r_last", 64'(r_last), 64'(b == int'(len)));
      chk("r_id", 64'(r_id), 64'(id));
      rdy = (pat_en && c < 32) ? rdy_pat[c] : 1'b1;
      r_ready = rdy;
      @(negedge clock);
      c++;
      if (rdy) b++;
    end
    r_ready = 1'b0;
    chk("r_valid_after_last", 64'(r_valid), 64'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] rdata;
  } vec_t;

  initial begin : main
    vec_t        tbl [12];
    logic [1:0]  resp;
    int          nb;
    logic [63:0] a;
    logic [7:0]  ln;
    int          lb;

    tbl[0]  = '{1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 2'b00, 64'd0};
    tbl[1]  = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 2'b00, 64'h1122334455667788};
    tbl[2]  = '{1'b1, 64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 64'd0};
    tbl[3]  = '{1'b1, 64'h8000_0018, 64'h1122334455667788, 8'h0F, 2'b00, 64'd0};
    tbl[4]  = '{1'b0, 64'h8000_0018, 64'd0, 8'h00, 2'b00, 64'hFFFF_FFFF_5566_7788};
    tbl[5]  = '{1'b0, 64'h8000_001C, 64'd0, 8'h00, 2'b00, 64'hFFFF_FFFF_5566_7788};
    tbl[6]  = '{1'b0, 64'h7000_0000, 64'd0, 8'h00, 2'b11, 64'd0};
    tbl[7]  = '{1'b1, 64'h7000_0000, 64'hDEAD_BEEF_0000_0001, 8'hFF, 2'b11, 64'd0};
    tbl[8]  = '{1'b1, 64'h8000_1FF8, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 2'b00, 64'd0};
    tbl[9]  = '{1'b1, 64'h8000_1FF8, 64'd0, 8'hF0, 2'b00, 64'd0};
    tbl[10] = '{1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 2'b00, 64'h0000_0000_A5A5_A5A5};
    tbl[11] = '{1'b0, 64'h8000_2000, 64'd0, 8'h00, 2'b11, 64'd0};

    reset = 1'b1;
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; r_ready = 0;
    repeat (3) @(negedge clock);
    chk("rst_aw_ready", 64'(aw_ready), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_outputs", {b_resp, b_id, r_resp, r_last, r_id}, 64'd0);
    chk("rst_r_data", r_data, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_aw_ready", 64'(aw_ready), 64'd1);
    chk("post_rst_ar_ready", 64'(ar_ready), 64'd1);

    // Fill the whole model window with long bursts so every read is predictable
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 256; b++) begin
        wbuf_d[b] = {$urandom, $urandom};
        wbuf_s[b] = 8'hFF;
      end
      do_write(BASE + 64'd2048 * 64'(k), 4'(k), 8'd255, 255, resp, nb);
      chk("prefill_beats", 64'(nb), 64'd256);
    end

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) begin
        wbuf_d[0] = tbl[i].data; wbuf_s[0] = tbl[i].strb;
        do_write(tbl[i].addr, 4'(i), 8'd0, 0, resp, nb);
        chk("tbl_b_resp", 64'(resp), 64'(tbl[i].resp));
      end else begin
        do_read(tbl[i].addr, 4'(i), 8'd0, 32'd0, 1'b0);
        chk("tbl_r_data", rd_data0, tbl[i].rdata);
        chk("tbl_r_resp", 64'(rd_resp0), 64'(tbl[i].resp));
      end
    end

    // Stalled 4-beat read: ready pattern 1,0,0,1,1,1
    do_read(BASE, 4'h5, 8'd3, 32'h0000_0039, 1'b1);

    // Out-of-range write burst must leave the aliased low words alone
    wbuf_d[0] = 64'hBAD0_0000_0000_0000; wbuf_s[0] = 8'hFF;
    wbuf_d[1] = 64'hBAD0_0000_0000_0001; wbuf_s[1] = 8'hFF;
    do_write(64'h7000_0000, 4'h3, 8'd1, 1, resp, nb);
    chk("oor_b_resp", 64'(resp), 64'd3);
    do_read(BASE, 4'h3, 8'd1, 32'd0, 1'b0);

    // Early w_last, then missing w_last
    for (int b = 0; b < 4; b++) begin wbuf_d[b] = 64'hC0DE_0000_0000_0000 + 64'(b); wbuf_s[b] = 8'hFF; end
    do_write(BASE + 64'h100, 4'h6, 8'd3, 1, resp, nb);
    chk("early_last_beats", 64'(nb), 64'd2);
    chk("early_last_resp", 64'(resp), 64'd2);
    do_read(BASE + 64'h100, 4'h6, 8'd3, 32'd0, 1'b0);
    do_write(BASE + 64'h200, 4'h7, 8'd1, 9, resp, nb);
    chk("no_last_beats", 64'(nb), 64'd2);
    chk("no_last_resp", 64'(resp), 64'd2);

    // Burst running off the top of the window: first beat lands, resp DECERR
    do_write(LIMIT - 64'd8, 4'h8, 8'd1, 1, resp, nb);
    chk("cross_end_resp", 64'(resp), 64'd3);
    do_read(LIMIT - 64'd8, 4'h8, 8'd1, 32'd0, 1'b0);

    // Reset during the second beat of a 4-beat read
    @(negedge clock);
    ar_valid = 1'b1; ar_addr = BASE + 64'h40; ar_id = 4'h9; ar_len = 8'd3;
    while (!ar_ready) @(negedge clock);
    @(negedge clock);
    ar_valid = 1'b0; r_ready = 1'b1;
    @(negedge clock);
    chk("mid_burst_valid", 64'(r_valid), 64'd1);
    chk("mid_burst_data", r_data, mem_m[widx(BASE + 64'h48)]);
    reset = 1'b1; r_ready = 1'b0;
    @(negedge clock);
    chk("midrst_r_valid", 64'(r_valid), 64'd0);
    chk("midrst_ar_ready", 64'(ar_ready), 64'd0);
    chk("midrst_r_fields", {r_resp, r_last, r_id}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("after_rst_ar_ready", 64'(ar_ready), 64'd1);
    chk("after_rst_r_valid", 64'(r_valid), 64'd0);
    do_read(BASE + 64'h40, 4'hA, 8'd2, 32'd0, 1'b0);

    // Random bursts against the model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       a = LIMIT - 64'd8 * 64'($urandom_range(0, 3));
        1:       a = BASE - 64'd8 * 64'($urandom_range(1, 3));
        default: a = BASE + 64'd8 * 64'($urandom_range(0, 1015));
      endcase
      a = a | 64'($urandom_range(0, 7));
      ln = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 8; b++) begin wbuf_d[b] = {$urandom, $urandom}; wbuf_s[b] = 8'($urandom); end
        lb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : int'(ln);
        do_write(a, 4'($urandom), ln, lb, resp, nb);
      end else begin
        do_read(a, 4'($urandom), ln, $urandom, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    die("global_watchdog");
  end

endmodule
`default_nettype wire
